// File: rtl/gb_pixel_fetch_if.sv
// Video-in / frame-buffer / video-out signal bundle for the Game Boy pixel fetcher.
// The master side is the timing generator plus the frame buffer. The slave side is the fetcher.
interface gb_pixel_fetch_if;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [14:0] mem_addr;
  logic [1:0]  mem_data;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [15:0] color;

  modport master (
    output de_in, hsync_in, vsync_in, mem_data,
    input  mem_addr, de_out, hsync_out, vsync_out, color
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, mem_data,
    output mem_addr, de_out, hsync_out, vsync_out, color
  );
endinterface

// File: rtl/gb_pixel_fetch.sv
// Upscales a GB_W x GB_H shade frame buffer by SCALE into a display raster.
// The pipeline has 2 clk of latency and places a border colour outside the image.
module gb_pixel_fetch #(
  parameter int unsigned GB_W         = 160,
  parameter int unsigned GB_H         = 144,
  parameter int unsigned SCALE        = 3,
  parameter int unsigned V_OFFSET     = 24,
  parameter logic [15:0] BORDER_COLOR = 16'h0000,
  parameter logic [15:0] PAL0         = 16'hFFFF,
  parameter logic [15:0] PAL1         = 16'hAD55,
  parameter logic [15:0] PAL2         = 16'h52AA,
  parameter logic [15:0] PAL3         = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  gb_pixel_fetch_if.slave bus
);

  localparam int unsigned       GX_W      = (GB_W > 1) ? $clog2(GB_W) : 1;
  localparam int unsigned       SUB_W     = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [9:0]        COL_END   = 10'(GB_W * SCALE);
  localparam logic [9:0]        ROW_LO    = 10'(V_OFFSET);
  localparam logic [9:0]        ROW_HI    = 10'(V_OFFSET + GB_H * SCALE);
  localparam logic [10:0]       ROW_FIRST = 11'(V_OFFSET);
  localparam logic [GX_W-1:0]   GX_MAX    = GX_W'(GB_W - 1);
  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(SCALE - 1);
  localparam logic [14:0]       BASE_STEP = 15'(GB_W);
  localparam logic [14:0]       BASE_MAX  = 15'((GB_H - 1) * GB_W);

  typedef enum logic {WAIT_VSYNC, RUN} state_t;

  state_t             state, state_next;
  logic               active;

  logic               de_d1, de_d2;
  logic               hs_d1, hs_d2;
  logic               vs_d1, vs_d2;
  logic               vs_prev;
  logic               de_fall, vs_fall;

  logic [9:0]         col, row;
  logic [SUB_W-1:0]   hsub, vsub;
  logic [GX_W-1:0]    gx;
  logic [14:0]        line_base;
  logic [14:0]        addr_hold, addr_next;
  logic               row_in_win, win0, win1;
  logic [15:0]        pal_color, color_q;

  assign de_fall = de_d1 & ~bus.de_in;
  assign vs_fall = vs_prev & ~bus.vsync_in;

  // No addressing until a vsync edge has established which line is row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_VSYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == WAIT_VSYNC && vs_fall) state_next = RUN;
  end

  always_comb begin
    active = (state == RUN);
  end

  assign row_in_win = (row >= ROW_LO) && (row < ROW_HI);
  assign win0       = active && bus.de_in && row_in_win && (col < COL_END);
  assign addr_next  = win0 ? (line_base + 15'(gx)) : addr_hold;

  // Raster counters. row and col saturate so that a runaway raster stays in the border.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b0;
      col       <= '0;
      row       <= '0;
      hsub      <= '0;
      gx        <= '0;
      vsub      <= '0;
      line_base <= '0;
      addr_hold <= '0;
    end else begin
      vs_prev   <= bus.vsync_in;
      addr_hold <= addr_next;

      if (bus.de_in) begin
        if (col != '1) col <= col + 10'd1;
        if (hsub == SUB_MAX) begin
          hsub <= '0;
          if (gx != GX_MAX) gx <= gx + 1'b1;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end else begin
        col  <= '0;
        hsub <= '0;
        gx   <= '0;
      end

      if (vs_fall) begin
        row       <= '0;
        vsub      <= '0;
        line_base <= '0;
      end else if (de_fall) begin
        if (row != '1) row <= row + 10'd1;
        if ({1'b0, row} + 11'd1 == ROW_FIRST) begin
          vsub      <= '0;
          line_base <= '0;
        end else if (row_in_win) begin
          if (vsub == SUB_MAX) begin
            vsub <= '0;
            if (line_base < BASE_MAX) line_base <= line_base + BASE_STEP;
          end else begin
            vsub <= vsub + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pal_color = PAL0;
    unique case (bus.mem_data)
      2'd0: pal_color = PAL0;
      2'd1: pal_color = PAL1;
      2'd2: pal_color = PAL2;
      2'd3: pal_color = PAL3;
    endcase
  end

  // mem_data arrives one clk after mem_addr, in the same cycle as the stage-1 flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_d1   <= 1'b0;
      de_d2   <= 1'b0;
      hs_d1   <= 1'b1;
      hs_d2   <= 1'b1;
      vs_d1   <= 1'b1;
      vs_d2   <= 1'b1;
      win1    <= 1'b0;
      color_q <= '0;
    end else begin
      de_d1   <= bus.de_in;
      de_d2   <= de_d1;
      hs_d1   <= bus.hsync_in;
      hs_d2   <= hs_d1;
      vs_d1   <= bus.vsync_in;
      vs_d2   <= vs_d1;
      win1    <= win0;
      color_q <= de_d1 ? (win1 ? pal_color : BORDER_COLOR) : '0;
    end
  end

  assign bus.mem_addr  = addr_next;
  assign bus.de_out    = de_d2;
  assign bus.hsync_out = hs_d2;
  assign bus.vsync_out = vs_d2;
  assign bus.color     = color_q;

endmodule

// File: tb/tb_gb_pixel_fetch.sv
// Randomised raster stimulus for gb_pixel_fetch, compared against a line/column reference model.
module tb_gb_pixel_fetch;

  localparam logic [15:0] BORDER = 16'h0000;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] color;
  } out_t;

  localparam out_t RESET_OUT = '{de: 1'b0, hs: 1'b1, vs: 1'b1, color: 16'h0000};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gb_pixel_fetch_if bus ();

  gb_pixel_fetch #(
    .GB_W(160), .GB_H(144), .SCALE(3), .V_OFFSET(24), .BORDER_COLOR(16'h0000),
    .PAL0(16'hFFFF), .PAL1(16'hAD55), .PAL2(16'h52AA), .PAL3(16'h0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Frame-buffer stand-in: the shade code is the low two bits of the address, returned one clk later.
  always @(posedge clk) bus.mem_data <= bus.mem_addr[1:0];

  int   n_checks = 0;
  int   n_errors = 0;

  int   m_line, m_col, m_last_addr;
  bit   m_synced, m_prev_de, m_prev_vs;
  out_t exp_q[$];

  function automatic logic [15:0] pal(input logic [1:0] s);
    case (s)
      2'd0:    return 16'hFFFF;
      2'd1:    return 16'hAD55;
      2'd2:    return 16'h52AA;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_line      = 0;
    m_col       = 0;
    m_last_addr = 0;
    m_synced    = 1'b0;
    m_prev_de   = 1'b0;
    m_prev_vs   = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_OUT);
    exp_q.push_back(RESET_OUT);
  endtask

  // Reset is asserted for one full clock. The reset values are checked straight away, before any edge.
  task automatic reset_cycle(input bit de, input bit hs, input bit vs);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.de_in    = de;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    #2;
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_de_out", 32'(bus.de_out), 32'd0);
    check("rst_hsync_out", 32'(bus.hsync_out), 32'd1);
    check("rst_vsync_out", 32'(bus.vsync_out), 32'd1);
    check("rst_color", 32'(bus.color), 32'd0);
    model_reset();
  endtask

  task automatic cycle(input bit de, input bit hs, input bit vs);
    bit   win;
    int   a, gx;
    out_t e;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.de_in    = de;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    #2;
    win = m_synced && de && (m_line >= 24) && (m_line < 24 + 144 * 3) && (m_col < 160 * 3);
    gx  = (m_col / 3 > 159) ? 159 : m_col / 3;
    a   = win ? ((m_line - 24) / 3) * 160 + gx : m_last_addr;

    check("mem_addr", 32'(bus.mem_addr), 32'(a));
    if (win && m_col == 0 && m_line == 24)  check("base_row24", 32'(bus.mem_addr), 32'd0);
    if (win && m_col == 0 && m_line == 27)  check("base_row27", 32'(bus.mem_addr), 32'd160);
    if (win && m_col == 0 && m_line == 455) check("base_row455", 32'(bus.mem_addr), 32'd22880);
    if (win && m_col == 479 && m_line == 455) check("last_addr", 32'(bus.mem_addr), 32'd23039);

    check("de_out", 32'(bus.de_out), 32'(exp_q[0].de));
    check("hsync_out", 32'(bus.hsync_out), 32'(exp_q[0].hs));
    check("vsync_out", 32'(bus.vsync_out), 32'(exp_q[0].vs));
    check("color", 32'(bus.color), 32'(exp_q[0].color));

    e.de    = de;
    e.hs    = hs;
    e.vs    = vs;
    e.color = de ? (win ? pal(2'(a)) : BORDER) : 16'h0000;
    void'(exp_q.pop_front());
    exp_q.push_back(e);

    if (m_prev_vs && !vs) begin
      m_line   = 0;
      m_synced = 1'b1;
    end else if (m_prev_de && !de) begin
      m_line++;
    end
    m_col       = de ? m_col + 1 : 0;
    m_prev_de   = de;
    m_prev_vs   = vs;
    m_last_addr = a;
  endtask

  task automatic blank();
    int n;
    n = int'($urandom_range(2, 6));
    for (int i = 0; i < n; i++) cycle(1'b0, (i == 0 || i == n - 1), 1'b1);
  endtask

  task automatic do_line(input int de_len);
    for (int i = 0; i < de_len; i++) cycle(1'b1, 1'b1, 1'b1);
    blank();
  endtask

  task automatic vsync_pulse();
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  function automatic int len_for(input int r);
    if (r == 24 || r == 25 || r == 26 || r == 27 || r == 455) return 480;
    if (r == 2 || r == 30 || r == 460) return 500;
    if (r == 100) return int'($urandom_range(40, 120));
    return int'($urandom_range(1, 12));
  endfunction

  task automatic run_rows(input int first, input int last);
    for (int r = first; r <= last; r++) do_line(len_for(r));
  endtask

  initial begin
    bus.de_in    = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.mem_data = 2'd0;
    model_reset();

    // Reset held while every input is toggled at random.
    for (int i = 0; i < 8; i++)
      reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Lines before the first vsync edge are border only.
    for (int i = 0; i < 3; i++) do_line(int'($urandom_range(3, 9)));

    // One full frame.
    vsync_pulse();
    run_rows(0, 479);

    // The next frame is cut short by a vsync edge after row 200.
    vsync_pulse();
    run_rows(0, 200);
    vsync_pulse();
    run_rows(0, 27);

    // Reset pulse in the middle of a line, followed by border until the next vsync.
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b1);
    reset_cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 379; i++) cycle(1'b1, 1'b1, 1'b1);
    blank();
    do_line(6);
    do_line(480);
    vsync_pulse();
    run_rows(0, 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
